// File: rtl/ccc_apb_reconfig_master.sv
// APB3 initiator for the CCC dynamic-reconfiguration port, with a PLL relock
// command that pulses PLL_ARST_N and then waits for a synchronized LOCK.
module ccc_apb_reconfig_master #(
  parameter int ARST_CYCLES  = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic       PCLK,
  input  logic       PRESET_N,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [5:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [5:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       BUSY,
  output logic       PLL_ARST_N,
  input  logic       LOCK
);

  localparam int BW = $clog2(BUSY_TIMEOUT + 1);
  localparam int AW = $clog2(ARST_CYCLES + 1);
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [BW-1:0] BUSY_LAST = BW'(BUSY_TIMEOUT - 1);
  localparam logic [AW-1:0] ARST_LAST = AW'(ARST_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_TIMEOUT - 1);
  localparam logic [1:0] OP_WR = 2'b00, OP_RD = 2'b01, OP_RELOCK = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACCESS, S_ARST, S_WAIT_LOCK, S_RESP
  } state_t;

  state_t state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [5:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [BW-1:0] busy_cnt_q, busy_cnt_d;
  logic [AW-1:0] arst_cnt_q, arst_cnt_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          pll_arst_n_q, pll_arst_n_d;
  logic          lock_m_q, lock_s_q;

  always_ff @(posedge PCLK) begin
    if (!PRESET_N) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      busy_cnt_q   <= '0;
      arst_cnt_q   <= '0;
      lock_cnt_q   <= '0;
      pll_arst_n_q <= 1'b1;
      lock_m_q     <= 1'b0;
      lock_s_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      busy_cnt_q   <= busy_cnt_d;
      arst_cnt_q   <= arst_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      pll_arst_n_q <= pll_arst_n_d;
      lock_m_q     <= LOCK;
      lock_s_q     <= lock_m_q;
    end
  end

  // Counters default to zero so each one is clear on entry to its own state.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    busy_cnt_d = '0;
    arst_cnt_d = '0;
    lock_cnt_d = '0;
    case (state_q)
      S_IDLE: begin
        rdata_d = '0;
        err_d   = 1'b0;
        if (cmd_valid) begin
          op_d = cmd_op;
          if (cmd_op == OP_WR || cmd_op == OP_RD) begin
            addr_d  = cmd_addr;
            wdata_d = cmd_wdata;
            state_d = S_SETUP;
          end else if (cmd_op == OP_RELOCK) begin
            state_d = S_ARST;
          end else begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (!BUSY) begin
          if (op_q == OP_RD) rdata_d = PRDATA;
          state_d = S_RESP;
        end else if (busy_cnt_q == BUSY_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          busy_cnt_d = busy_cnt_q + BW'(1);
        end
      end
      S_ARST: begin
        if (arst_cnt_q == ARST_LAST) state_d = S_WAIT_LOCK;
        else arst_cnt_d = arst_cnt_q + AW'(1);
      end
      S_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = S_RESP;
        end else if (lock_cnt_q == LOCK_LAST) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          lock_cnt_d = lock_cnt_q + LW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // PLL reset is registered so the CCC never sees a decode glitch.
  assign pll_arst_n_d = (state_d != S_ARST);

  always_comb begin
    cmd_ready  = (state_q == S_IDLE);
    rsp_valid  = (state_q == S_RESP);
    rsp_err    = (state_q == S_RESP) && err_q;
    rsp_rdata  = (state_q == S_RESP) ? rdata_q : 8'h00;
    PSEL       = (state_q == S_SETUP) || (state_q == S_ACCESS);
    PENABLE    = (state_q == S_ACCESS);
    PWRITE     = PSEL && (op_q == OP_WR);
    PADDR      = addr_q;
    PWDATA     = wdata_q;
    PLL_ARST_N = pll_arst_n_q;
  end

endmodule

// File: tb/tb_ccc_apb_reconfig_master.sv
// Bench for ccc_apb_reconfig_master: directed and random commands checked
// cycle by cycle against a transaction-level timing model.
module tb_ccc_apb_reconfig_master;
  localparam int ARST_CYCLES  = 16;
  localparam int LOCK_TIMEOUT = 20;
  localparam int BUSY_TIMEOUT = 4;

  logic       PCLK = 1'b0;
  logic       PRESET_N;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [5:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       PSEL, PENABLE, PWRITE;
  logic [5:0] PADDR;
  logic [7:0] PWDATA, PRDATA;
  logic       BUSY, PLL_ARST_N, LOCK;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 PCLK = ~PCLK;

  ccc_apb_reconfig_master #(
    .ARST_CYCLES (ARST_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .PCLK      (PCLK),
    .PRESET_N  (PRESET_N),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .BUSY      (BUSY),
    .PLL_ARST_N(PLL_ARST_N),
    .LOCK      (LOCK)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // nbusy: BUSY-high ACCESS cycles before completion; dly: cycles after PLL
  // reset release at which LOCK rises (beyond the window means never).
  task automatic run_cmd(input logic [1:0] op, input logic [5:0] addr, input logic [7:0] wdata,
                         input int nbusy, input logic [7:0] prdata, input int dly);
    int r;
    int w;
    logic exp_err;
    logic [7:0] exp_rd;
    logic psel_e, pen_e;
    w = 1 + ARST_CYCLES;
    case (op)
      2'b00, 2'b01: begin
        if (nbusy < BUSY_TIMEOUT) begin
          r = 3 + nbusy; exp_err = 1'b0; exp_rd = (op == 2'b01) ? prdata : 8'h00;
        end else begin
          r = 2 + BUSY_TIMEOUT; exp_err = 1'b1; exp_rd = 8'h00;
        end
      end
      2'b10: begin
        exp_rd = 8'h00;
        if (dly + 3 <= LOCK_TIMEOUT) begin
          r = w + dly + 3; exp_err = 1'b0;
        end else begin
          r = w + LOCK_TIMEOUT; exp_err = 1'b1;
        end
      end
      default: begin
        r = 1; exp_err = 1'b1; exp_rd = 8'h00;
      end
    endcase

    @(posedge PCLK); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wdata;
    BUSY = 1'b0; LOCK = 1'b0;
    @(negedge PCLK);
    chk("ready_before_accept", cmd_ready, 1);
    @(posedge PCLK);
    for (int k = 1; k <= r + 1; k++) begin
      #1;
      if (k < r) begin
        cmd_valid = 1'($urandom); cmd_op = 2'($urandom);
        cmd_addr = 6'($urandom); cmd_wdata = 8'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      BUSY   = (op[1] == 1'b0) && (k >= 2) && (k < 2 + nbusy);
      PRDATA = BUSY ? 8'($urandom) : prdata;
      LOCK   = (op == 2'b10) && (k >= w + dly);
      @(negedge PCLK);
      psel_e = (op[1] == 1'b0) && (k >= 1) && (k < r);
      pen_e  = (op[1] == 1'b0) && (k >= 2) && (k < r);
      chk("rsp_valid", rsp_valid, k == r);
      chk("cmd_ready", cmd_ready, k > r);
      chk("psel", PSEL, psel_e);
      chk("penable", PENABLE, pen_e);
      chk("pwrite", PWRITE, psel_e && (op == 2'b00));
      chk("pll_arst_n", PLL_ARST_N, !((op == 2'b10) && (k <= ARST_CYCLES)));
      if (psel_e) begin
        chk("paddr", PADDR, addr);
        chk("pwdata", PWDATA, wdata);
      end
      if (k == r) begin
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_rdata", rsp_rdata, exp_rd);
      end
      @(posedge PCLK);
    end
  endtask

  initial begin
    PRESET_N = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_wdata = '0;
    PRDATA = '0; BUSY = 1'b0; LOCK = 1'b0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_pll_arst_n", PLL_ARST_N, 1);
    @(posedge PCLK); #1 PRESET_N = 1'b1;

    run_cmd(2'b00, 6'h05, 8'hA3, 0, 8'h00, 0);
    run_cmd(2'b01, 6'h1F, 8'h00, 3, 8'h5C, 0);
    run_cmd(2'b00, 6'h11, 8'h3C, 50, 8'h00, 0);
    run_cmd(2'b01, 6'h22, 8'h00, 50, 8'hEE, 0);
    run_cmd(2'b10, 6'h00, 8'h00, 0, 8'h00, 10);
    run_cmd(2'b10, 6'h00, 8'h00, 0, 8'h00, 1000);
    run_cmd(2'b11, 6'h3F, 8'hFF, 0, 8'h00, 0);
    run_cmd(2'b10, 6'h00, 8'h00, 0, 8'h00, 0);
    run_cmd(2'b10, 6'h00, 8'h00, 0, 8'h00, LOCK_TIMEOUT - 3);
    run_cmd(2'b10, 6'h00, 8'h00, 0, 8'h00, LOCK_TIMEOUT - 2);

    // Reset while in ACCESS with BUSY held high
    @(posedge PCLK); #1;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 6'h2A; cmd_wdata = 8'h77; BUSY = 1'b1;
    @(posedge PCLK); #1 cmd_valid = 1'b0;
    @(posedge PCLK);
    @(posedge PCLK); #1 PRESET_N = 1'b0;
    @(negedge PCLK);
    chk("mid_psel", PSEL, 1);
    chk("mid_penable", PENABLE, 1);
    @(posedge PCLK);
    @(negedge PCLK);
    chk("abort_psel", PSEL, 0);
    chk("abort_penable", PENABLE, 0);
    chk("abort_pll", PLL_ARST_N, 1);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_paddr", PADDR, 0);
    @(posedge PCLK); #1 PRESET_N = 1'b1; BUSY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk("post_abort_rsp", rsp_valid, 0);
      chk("post_abort_ready", cmd_ready, 1);
    end

    // Reset while the PLL reset is asserted
    @(posedge PCLK); #1;
    cmd_valid = 1'b1; cmd_op = 2'b10;
    @(posedge PCLK); #1 cmd_valid = 1'b0;
    repeat (4) @(posedge PCLK);
    @(negedge PCLK);
    chk("arst_low", PLL_ARST_N, 0);
    #1 PRESET_N = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    chk("arst_abort_pll", PLL_ARST_N, 1);
    chk("arst_abort_ready", cmd_ready, 1);
    @(posedge PCLK); #1 PRESET_N = 1'b1;

    for (int i = 0; i < 40; i++) begin
      run_cmd(2'($urandom), 6'($urandom), 8'($urandom), int'($urandom_range(0, 6)),
              8'($urandom), int'($urandom_range(0, 25)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
